// File: rtl/jesd204_tx_link_seq_pkg.sv
// Purpose: shared types and constants for the JESD204 TX link sequencer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package jesd204_tx_link_seq_pkg;

  // Link state encoding, also driven out directly as status_state.
  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } link_state_t;

  // 8b/10b control characters used by the link layer.
  localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma, code group sync
  localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
  localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
  localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows

  // Number of beats of the second ILAS multiframe that carry link config.
  localparam int unsigned ILAS_CFG_BEATS = 4;

  // What an output octet carries; decoded in S1, turned into bytes in S2.
  typedef enum logic [2:0] {
    OCT_K28_5,
    OCT_K28_0,
    OCT_K28_3,
    OCT_K28_4,
    OCT_CFG,
    OCT_CNT,
    OCT_ZERO
  } octet_kind_t;

  // Octet kind for an ILAS position; earlier tests take priority.
  // cfg_beat is true for the config-carrying beats of the config multiframe.
  function automatic octet_kind_t ilas_octet_kind(
    input logic first_octet,
    input logic second_octet,
    input logic last_octet,
    input logic first_beat,
    input logic last_beat,
    input logic cfg_beat
  );
    octet_kind_t kind;
    if (first_beat && first_octet)
      kind = OCT_K28_0;
    else if (last_beat && last_octet)
      kind = OCT_K28_3;
    else if (cfg_beat && first_beat && second_octet)
      kind = OCT_K28_4;
    else if (cfg_beat)
      kind = OCT_CFG;
    else
      kind = OCT_CNT;
    return kind;
  endfunction

endpackage

// File: rtl/jesd204_tx_link_seq_beat_cnt.sv
// Purpose: beat-in-multiframe and ILAS multiframe counters.
// Latency: counters update one cycle after load/wrap; last_beat is combinational.
// Backpressure: none, free-running every cycle.
//
// Ports: clk/resetn; cfg_beats_per_multiframe (beats minus one); load zeroes
// both counters on a state entry; in_ilas enables multiframe counting;
// beat_cnt/mf_cnt are the counters; last_beat flags the final beat.
module jesd204_tx_link_seq_beat_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] cfg_beats_per_multiframe,
  input  logic       load,
  input  logic       in_ilas,
  output logic [7:0] beat_cnt,
  output logic [7:0] mf_cnt,
  output logic       last_beat
);

  assign last_beat = (beat_cnt == cfg_beats_per_multiframe);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= 8'd0;
      mf_cnt   <= 8'd0;
    end else if (load) begin
      beat_cnt <= 8'd0;
      mf_cnt   <= 8'd0;
    end else if (last_beat) begin
      beat_cnt <= 8'd0;
      if (in_ilas)
        mf_cnt <= mf_cnt + 8'd1;
    end else begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/jesd204_tx_link_seq.sv
// Purpose: JESD204 TX link sequencer, CGS -> ILAS -> DATA with SYNC-driven fallback.
// Latency: tx_data/tx_charisk trail the state register by 2 cycles; status is direct.
// Backpressure: none; a lane beat is produced every cycle.
//
// Ports: clk/resetn; cfg_beats_per_multiframe, cfg_disable_ilas (static config);
// sync_n, lmfc_edge (link timing); ilas_config_rd/addr/data (config memory,
// data returned one cycle after rd); tx_data/tx_charisk (lane octets, octet 0
// in LSBs); status_state; ilas_done (one-cycle pulse when ILAS completes).
module jesd204_tx_link_seq
  import jesd204_tx_link_seq_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = 4,
  parameter int ILAS_MF_COUNT   = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [7:0]                   cfg_beats_per_multiframe,
  input  logic                         cfg_disable_ilas,
  input  logic                         sync_n,
  input  logic                         lmfc_edge,
  output logic                         ilas_config_rd,
  output logic [1:0]                   ilas_config_addr,
  input  logic [DATA_PATH_WIDTH*8-1:0] ilas_config_data,
  output logic [DATA_PATH_WIDTH*8-1:0] tx_data,
  output logic [DATA_PATH_WIDTH-1:0]   tx_charisk,
  output logic [1:0]                   status_state,
  output logic                         ilas_done
);

  localparam int         OW      = DATA_PATH_WIDTH * 8;
  localparam logic [7:0] MF_LAST = 8'(ILAS_MF_COUNT - 1);

  // ---------------- S0: state and counters ----------------
  link_state_t state;
  logic [7:0]  beat_cnt;
  logic [7:0]  mf_cnt;
  logic        last_beat;
  logic        cgs_exit;
  logic        ilas_last;
  logic        sync_lost;
  logic        state_load;
  logic        cfg_beat;

  assign cgs_exit   = (state == ST_CGS) && lmfc_edge && sync_n;
  assign ilas_last  = (state == ST_ILAS) && last_beat && (mf_cnt == MF_LAST);
  assign sync_lost  = (state != ST_CGS) && !sync_n;
  // Any state change restarts the beat/multiframe count.
  assign state_load = cgs_exit || ilas_last || sync_lost;

  jesd204_tx_link_seq_beat_cnt u_beat_cnt (
    .clk                      (clk),
    .resetn                   (resetn),
    .cfg_beats_per_multiframe (cfg_beats_per_multiframe),
    .load                     (state_load),
    .in_ilas                  (state == ST_ILAS),
    .beat_cnt                 (beat_cnt),
    .mf_cnt                   (mf_cnt),
    .last_beat                (last_beat)
  );

  // SYNC loss wins over every other transition, including the end of ILAS,
  // in which case ilas_done is suppressed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_CGS;
      ilas_done <= 1'b0;
    end else begin
      ilas_done <= 1'b0;
      if (sync_lost) begin
        state <= ST_CGS;
      end else begin
        case (state)
          ST_CGS: begin
            if (cgs_exit)
              state <= cfg_disable_ilas ? ST_DATA : ST_ILAS;
          end
          ST_ILAS: begin
            if (ilas_last) begin
              state     <= ST_DATA;
              ilas_done <= 1'b1;
            end
          end
          ST_DATA: state <= ST_DATA;
          default: state <= ST_CGS;
        endcase
      end
    end
  end

  assign status_state = state;

  // Config memory is read straight from S0 so its data lands alongside the
  // S1 decode of the same beat.
  assign cfg_beat         = (state == ST_ILAS) && (mf_cnt == 8'd1) &&
                            (beat_cnt < 8'(ILAS_CFG_BEATS));
  assign ilas_config_rd   = cfg_beat;
  assign ilas_config_addr = cfg_beat ? beat_cnt[1:0] : 2'd0;

  // ---------------- S1: octet-type decode ----------------
  octet_kind_t kind_d [DATA_PATH_WIDTH];
  octet_kind_t kind_q [DATA_PATH_WIDTH];
  logic [7:0]  beat_q;

  always_comb begin
    for (int n = 0; n < DATA_PATH_WIDTH; n++) begin
      kind_d[n] = OCT_ZERO;
      case (state)
        ST_CGS:  kind_d[n] = OCT_K28_5;
        ST_ILAS: kind_d[n] = ilas_octet_kind(n == 0, n == 1,
                                             n == DATA_PATH_WIDTH - 1,
                                             beat_cnt == 8'd0, last_beat,
                                             cfg_beat);
        default: kind_d[n] = OCT_ZERO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int n = 0; n < DATA_PATH_WIDTH; n++)
        kind_q[n] <= OCT_K28_5;
      beat_q <= 8'd0;
    end else begin
      for (int n = 0; n < DATA_PATH_WIDTH; n++)
        kind_q[n] <= kind_d[n];
      beat_q <= beat_cnt;
    end
  end

  // ---------------- S2: output register ----------------
  logic [OW-1:0]              data_d;
  logic [DATA_PATH_WIDTH-1:0] charisk_d;

  always_comb begin
    data_d    = '0;
    charisk_d = '0;
    for (int n = 0; n < DATA_PATH_WIDTH; n++) begin
      case (kind_q[n])
        OCT_K28_5: begin data_d[n*8 +: 8] = K28_5; charisk_d[n] = 1'b1; end
        OCT_K28_0: begin data_d[n*8 +: 8] = K28_0; charisk_d[n] = 1'b1; end
        OCT_K28_3: begin data_d[n*8 +: 8] = K28_3; charisk_d[n] = 1'b1; end
        OCT_K28_4: begin data_d[n*8 +: 8] = K28_4; charisk_d[n] = 1'b1; end
        OCT_CFG:   data_d[n*8 +: 8] = ilas_config_data[n*8 +: 8];
        // Running octet index within the multiframe, wrapping mod 256.
        OCT_CNT:   data_d[n*8 +: 8] = beat_q * 8'(DATA_PATH_WIDTH) + 8'(n);
        default:   data_d[n*8 +: 8] = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_data    <= {DATA_PATH_WIDTH{K28_5}};
      tx_charisk <= '1;
    end else begin
      tx_data    <= data_d;
      tx_charisk <= charisk_d;
    end
  end

endmodule

// File: tb/tb_jesd204_tx_link_seq.sv
// Purpose: self-checking bench for jesd204_tx_link_seq against a timeline model.
// Latency: model expects outputs 2 cycles behind status_state.
// Backpressure: n/a.
module tb_jesd204_tx_link_seq;

  localparam int DPW  = 4;
  localparam int MFC  = 4;
  localparam int NONE = 100000;

  logic        clk;
  logic        resetn;
  logic [7:0]  cfg_beats;
  logic        cfg_disable;
  logic        sync_n;
  logic        lmfc_edge;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] cfg_data;
  logic [31:0] tx_data;
  logic [3:0]  charisk;
  logic [1:0]  status;
  logic        done;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  jesd204_tx_link_seq #(
    .DATA_PATH_WIDTH (DPW),
    .ILAS_MF_COUNT   (MFC)
  ) dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .cfg_beats_per_multiframe (cfg_beats),
    .cfg_disable_ilas         (cfg_disable),
    .sync_n                   (sync_n),
    .lmfc_edge                (lmfc_edge),
    .ilas_config_rd           (rd),
    .ilas_config_addr         (addr),
    .ilas_config_data         (cfg_data),
    .tx_data                  (tx_data),
    .tx_charisk               (charisk),
    .status_state             (status),
    .ilas_done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Config memory: 0xA0+addr in every octet one cycle after a read, junk otherwise.
  always @(posedge clk)
    cfg_data <= rd ? {4{8'hA0 + {6'd0, addr}}} : $urandom;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected lane beat b of ILAS multiframe mf, from the octet rules.
  function automatic void ilas_beat(input int cfg, input int mf, input int b,
                                    output logic [31:0] d, output logic [3:0] kf);
    logic [7:0] v;
    logic       kk;
    d  = '0;
    kf = '0;
    for (int n = 0; n < DPW; n++) begin
      v  = 8'((b * DPW + n) % 256);
      kk = 1'b0;
      if (mf == 1 && b < 4)            v = 8'(8'hA0 + b);
      if (mf == 1 && b == 0 && n == 1) begin v = 8'h9C; kk = 1'b1; end
      if (b == cfg && n == DPW - 1)    begin v = 8'h7C; kk = 1'b1; end
      if (b == 0 && n == 0)            begin v = 8'h1C; kk = 1'b1; end
      d[n*8 +: 8] = v;
      kf[n]       = kk;
    end
  endfunction

  // Link timeline: cycle k after the lmfc edge -> state (0/1/2), mf, beat.
  function automatic void model_s0(input int k, input int cfg, input bit skip,
                                   input int abort_at,
                                   output int st, output int mf, output int b);
    int len;
    len = MFC * (cfg + 1);
    mf  = 0;
    b   = 0;
    if (k < 0 || k > abort_at) st = 0;
    else if (skip)             st = 2;
    else if (k < len) begin
      st = 1;
      mf = k / (cfg + 1);
      b  = k % (cfg + 1);
    end else                   st = 2;
  endfunction

  function automatic void model_out(input int st, input int mf, input int b, input int cfg,
                                    output logic [31:0] d, output logic [3:0] kf);
    if (st == 0) begin
      d  = 32'hBCBCBCBC;
      kf = 4'hF;
    end else if (st == 1) begin
      ilas_beat(cfg, mf, b, d, kf);
    end else begin
      d  = 32'h0;
      kf = 4'h0;
    end
  endfunction

  // Reset asserted between clock edges; outputs must take reset values at once.
  task automatic apply_reset(input int cfg, input bit skip);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("rst status",  32'(status),  32'd0);
    check("rst tx_data", tx_data,      32'hBCBCBCBC);
    check("rst charisk", 32'(charisk), 32'hF);
    check("rst done",    32'(done),    32'd0);
    check("rst rd",      32'(rd),      32'd0);
    check("rst addr",    32'(addr),    32'd0);
    cfg_beats   = 8'(cfg);
    cfg_disable = skip;
    sync_n      = 1'b1;
    lmfc_edge   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run_link(input int cfg, input bit skip, input int abort_at,
                          input int pre, input int n_cyc);
    int          len, st, mf, b, pst, pmf, pb;
    logic [31:0] ed;
    logic [3:0]  ek;
    bit          exp_done, exp_rd;
    len = MFC * (cfg + 1);
    apply_reset(cfg, skip);
    // CGS: lmfc_edge while sync_n=0 must not leave CGS.
    for (int j = 0; j < pre; j++) begin
      @(negedge clk);
      check("cgs status",  32'(status),  32'd0);
      check("cgs tx_data", tx_data,      32'hBCBCBCBC);
      check("cgs charisk", 32'(charisk), 32'hF);
      check("cgs rd",      32'(rd),      32'd0);
      if (j < pre - 1) begin
        sync_n    = 1'b0;
        lmfc_edge = 1'($urandom);
      end else begin
        sync_n    = 1'b1;
        lmfc_edge = 1'b1;
      end
    end
    for (int k = 0; k < n_cyc; k++) begin
      @(negedge clk);
      model_s0(k, cfg, skip, abort_at, st, mf, b);
      model_s0(k - 2, cfg, skip, abort_at, pst, pmf, pb);
      model_out(pst, pmf, pb, cfg, ed, ek);
      exp_done = !skip && (k == len) && (abort_at >= len);
      exp_rd   = (st == 1) && (mf == 1) && (b < 4);
      check($sformatf("status k=%0d", k),  32'(status),  32'(st));
      check($sformatf("tx_data k=%0d", k), tx_data,      ed);
      check($sformatf("charisk k=%0d", k), 32'(charisk), 32'(ek));
      check($sformatf("done k=%0d", k),    32'(done),    32'(exp_done));
      check($sformatf("rd k=%0d", k),      32'(rd),      32'(exp_rd));
      check($sformatf("addr k=%0d", k),    32'(addr),    exp_rd ? 32'(b) : 32'd0);
      // Literal beats of the reference sequences.
      if (cfg == 7 && !skip && abort_at == NONE) begin
        if (k == 2)  check("lit mf0 b0", tx_data, 32'h0302011C);
        if (k == 9)  check("lit mf0 b7", tx_data, 32'h7C1E1D1C);
        if (k == 10) begin
          check("lit mf1 b0",   tx_data,      32'hA0A09C1C);
          check("lit mf1 b0 k", 32'(charisk), 32'h3);
        end
        if (k == 33) begin
          check("lit mf3 b7",   tx_data,      32'h7C1E1D1C);
          check("lit mf3 b7 k", 32'(charisk), 32'h8);
        end
      end
      if (cfg == 0 && !skip && abort_at == NONE && k >= 2 && k <= 5)
        check($sformatf("lit single k=%0d", k), tx_data,
              (k == 3) ? 32'h7CA09C1C : 32'h7C02011C);
      // Drive for the next edge.
      sync_n    = (k >= abort_at && k < abort_at + 4) ? 1'b0 : 1'b1;
      lmfc_edge = (st != 0 || !sync_n) ? 1'($urandom) : 1'b0;
    end
  endtask

  initial begin
    int cfg, len, abort_at, pre;
    bit skip;
    resetn      = 1'b1;
    sync_n      = 1'b1;
    lmfc_edge   = 1'b0;
    cfg_beats   = 8'd7;
    cfg_disable = 1'b0;

    run_link(7, 1'b0, NONE, 3, 45);  // full ILAS, ends in DATA
    run_link(7, 1'b1, NONE, 2, 20);  // ILAS skipped; next reset hits DATA
    run_link(7, 1'b0, 19,   4, 36);  // SYNC lost in mf 2 beat 3
    run_link(7, 1'b0, 31,   2, 40);  // SYNC lost on the final ILAS beat
    run_link(0, 1'b0, NONE, 2, 12);  // single-beat multiframe

    for (int r = 0; r < 8; r++) begin
      cfg      = $urandom_range(0, 12);
      skip     = ($urandom_range(0, 3) == 0);
      len      = MFC * (cfg + 1);
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + 5) : NONE;
      pre      = $urandom_range(1, 6);
      run_link(cfg, skip, abort_at, pre, len + 10);
    end

    run_link(3, 1'b1, NONE, 1, 6);
    apply_reset(7, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
